// File: rtl/maze_pkg.sv
// Shared types and map geometry for the maze level controller.
package maze_pkg;

  localparam int unsigned MAP_ROWS = 48;
  localparam int unsigned MAP_COLS = 64;
  localparam int unsigned MAP_BITS = 3072;
  localparam int unsigned ROW_W    = 6;
  localparam int unsigned COL_W    = 6;
  localparam int unsigned IDX_W    = 12;
  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned LVL_W    = 3;
  localparam int unsigned TICK_W   = 8;

  typedef enum logic [1:0] {
    TITLE  = 2'd0,
    SETTLE = 2'd1,
    PLAY   = 2'd2,
    END    = 2'd3
  } state_t;

  // One tile query as presented by a requester.
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } tile_req_t;

  // Wall lookup; rows past the bottom of the map read as solid wall.
  function automatic logic tile_is_wall(input logic [MAP_BITS-1:0] map,
                                        input tile_req_t             q);
    logic [IDX_W-1:0] idx;
    idx = {q.row, q.col};
    if (q.row >= ROW_W'(MAP_ROWS)) begin
      return 1'b1;
    end
    return map[idx];
  endfunction

endpackage

// File: rtl/collision_rr_arbiter.sv
// Two-way round-robin tile-query arbiter with registered wall response.
module collision_rr_arbiter
  import maze_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_en,
  input  logic [MAP_BITS-1:0]             i_map,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ-1:0][ROW_W-1:0]   i_req_row,
  input  logic [NUM_REQ-1:0][COL_W-1:0]   i_req_col,
  output logic [NUM_REQ-1:0]              o_req_ready_c,
  output logic [NUM_REQ-1:0]              o_rsp_valid,
  output logic [NUM_REQ-1:0]              o_rsp_wall
);

  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [NUM_REQ-1:0] r_rsp_wall;
  logic               r_ptr;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_wall;
  tile_req_t          w_q [NUM_REQ];

  // Grant selection: a lone requester always wins, contention goes to r_ptr.
  always_comb begin
    w_grant = '0;
    if (i_en) begin
      case (i_req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  // Map lookup for each requester's current query.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_q[i].row = i_req_row[i];
      w_q[i].col = i_req_col[i];
      w_wall[i]  = tile_is_wall(i_map, w_q[i]);
    end
  end

  // Pointer advance and one-cycle response capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr       <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_wall  <= '0;
    end else begin
      if (|w_grant) begin
        r_ptr <= ~w_grant[1];
      end
      r_rsp_valid <= w_grant;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (w_grant[i]) begin
          r_rsp_wall[i] <= w_wall[i];
        end
      end
    end
  end

  assign o_req_ready_c = w_grant;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_wall    = r_rsp_wall;

endmodule

// File: rtl/maze_level_ctrl.sv
// Maze game level sequencer: title, settle delay, play, end screen.
module maze_level_ctrl
  import maze_pkg::*;
#(
  parameter int unsigned NUM_LEVELS    = 3,
  parameter int unsigned SETTLE_FRAMES = 30
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_tick,
  input  logic                          start,
  input  logic                          goal_reached,
  input  logic                          restart,
  output logic [LVL_W-1:0]              count,
  output logic                          E_STATE,
  input  logic [MAP_BITS-1:0]           C_map,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][ROW_W-1:0] req_row,
  input  logic [NUM_REQ-1:0][COL_W-1:0] req_col,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ-1:0]            rsp_wall,
  output logic                          transition
);

  localparam logic [LVL_W-1:0]  LEVEL_MAX = LVL_W'(NUM_LEVELS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SETTLE_FRAMES - 1);

  state_t              r_state;
  logic [LVL_W-1:0]    r_level;
  logic [TICK_W-1:0]   r_tick;

  state_t              w_state_nxt;
  logic [LVL_W-1:0]    w_level_nxt;
  logic [TICK_W-1:0]   w_tick_nxt;
  logic [LVL_W-1:0]    w_count;
  logic                w_e_state;
  logic                w_transition;
  logic                w_play;

  // State, level and settle-tick registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= TITLE;
      r_level <= '0;
      r_tick  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Next-state and ROM-select decode; restart overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_level_nxt  = r_level;
    w_tick_nxt   = r_tick;
    w_count      = '0;
    w_e_state    = 1'b0;
    w_transition = 1'b0;
    w_play       = 1'b0;

    case (r_state)
      TITLE: begin
        if (start) begin
          w_state_nxt = SETTLE;
          w_level_nxt = LVL_W'(1);
          w_tick_nxt  = '0;
        end
      end
      SETTLE: begin
        w_count      = r_level;
        w_transition = 1'b1;
        if (frame_tick) begin
          if (r_tick == TICK_LAST) begin
            w_state_nxt = PLAY;
            w_tick_nxt  = '0;
          end else begin
            w_tick_nxt = r_tick + TICK_W'(1);
          end
        end
      end
      PLAY: begin
        w_count = r_level;
        w_play  = 1'b1;
        if (goal_reached) begin
          if (r_level < LEVEL_MAX) begin
            w_state_nxt = SETTLE;
            w_level_nxt = r_level + LVL_W'(1);
            w_tick_nxt  = '0;
          end else begin
            w_state_nxt = END;
          end
        end
      end
      END: begin
        // Count stays nonzero here: the ROM checks count==0 before E_STATE.
        w_count   = LEVEL_MAX;
        w_e_state = 1'b1;
      end
      default: begin
        w_state_nxt = TITLE;
      end
    endcase

    if (restart) begin
      w_state_nxt = TITLE;
      w_level_nxt = '0;
      w_tick_nxt  = '0;
    end
  end

  assign count      = w_count;
  assign E_STATE    = w_e_state;
  assign transition = w_transition;

  // Tile-query arbitration, only open for business during PLAY.
  collision_rr_arbiter u_arb (
    .i_clk         (Clk),
    .i_reset       (Reset),
    .i_en          (w_play),
    .i_map         (C_map),
    .i_req_valid   (req_valid),
    .i_req_row     (req_row),
    .i_req_col     (req_col),
    .o_req_ready_c (req_ready),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_wall    (rsp_wall)
  );

endmodule

// File: tb/tb_maze_level_ctrl.sv
// Directed bench for maze_level_ctrl with hand-computed expectations.
module tb_maze_level_ctrl;
  import maze_pkg::*;

  logic                          Clk = 1'b0;
  logic                          Reset;
  logic                          frame_tick;
  logic                          start;
  logic                          goal_reached;
  logic                          restart;
  logic [2:0]                    count;
  logic                          E_STATE;
  logic [MAP_BITS-1:0]           C_map;
  logic [1:0]                    req_valid;
  logic [1:0][5:0]               req_row;
  logic [1:0][5:0]               req_col;
  logic [1:0]                    req_ready;
  logic [1:0]                    rsp_valid;
  logic [1:0]                    rsp_wall;
  logic                          transition;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned th_cnt = 0;

  maze_level_ctrl #(.NUM_LEVELS(3), .SETTLE_FRAMES(30)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .goal_reached (goal_reached),
    .restart      (restart),
    .count        (count),
    .E_STATE      (E_STATE),
    .C_map        (C_map),
    .req_valid    (req_valid),
    .req_row      (req_row),
    .req_col      (req_col),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_wall     (rsp_wall),
    .transition   (transition)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // n frame ticks, one idle cycle between each; counts ticks seen in SETTLE.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      if (transition) th_cnt++;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; start = 1'b0; goal_reached = 1'b0; restart = 1'b0;
    C_map = '0; C_map[133] = 1'b1;
    req_valid = 2'b00; req_row = '0; req_col = '0;
    step(); step();
    Reset = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rst_count",     32'(count),      32'd0);
    chk("rst_estate",    32'(E_STATE),    32'd0);
    chk("rst_trans",     32'(transition), 32'd0);
    chk("rst_ready",     32'(req_ready),  32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
    chk("rst_rsp_wall",  32'(rsp_wall),   32'd0);
    req_valid = 2'b00;

    // Title -> settle level 1 -> play after 30 ticks.
    start = 1'b1; step(); start = 1'b0;
    chk("start_count", 32'(count), 32'd1);
    chk("start_trans", 32'(transition), 32'd1);
    th_cnt = 0;
    frames(29);
    chk("settle_29_trans", 32'(transition), 32'd1);
    frames(1);
    chk("settle_30_trans", 32'(transition), 32'd0);
    chk("settle_th_cnt",   th_cnt, 32'd30);
    chk("play1_count",     32'(count), 32'd1);

    // Contention: grants alternate 0,1,0,1 with responses a cycle later.
    req_row[0] = 6'd2; req_col[0] = 6'd5;
    req_row[1] = 6'd0; req_col[1] = 6'd0;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      chk("rr_rsp_valid", 32'(rsp_valid), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_rsp_wall",  32'(rsp_wall), 32'd1);
    end
    req_valid = 2'b00;
    step();
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_rsp_wall_hold", 32'(rsp_wall), 32'd1);

    // Lone requester 1, row out of bounds.
    req_row[1] = 6'd50; req_valid = 2'b10;
    #1;
    chk("lone1_ready", 32'(req_ready), 32'd2);
    step(); req_valid = 2'b00;
    chk("oob_rsp_valid", 32'(rsp_valid), 32'd2);
    chk("oob_rsp_wall",  32'(rsp_wall),  32'd3);

    // Lone requester 0, open tile at origin.
    req_row[0] = 6'd0; req_col[0] = 6'd0; req_valid = 2'b01;
    #1;
    chk("lone0_ready", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00;
    chk("open_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("open_rsp_wall",  32'(rsp_wall),  32'd2);

    // Goal on level 1 -> settle level 2; goal/start ignored in settle.
    goal_reached = 1'b1; step(); goal_reached = 1'b0;
    chk("lvl2_count", 32'(count), 32'd2);
    chk("lvl2_trans", 32'(transition), 32'd1);
    req_valid = 2'b11;
    #1;
    chk("settle_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    goal_reached = 1'b1; start = 1'b1; step(); goal_reached = 1'b0; start = 1'b0;
    chk("settle_ign_count", 32'(count), 32'd2);
    chk("settle_ign_trans", 32'(transition), 32'd1);
    frames(30);
    chk("play2_trans", 32'(transition), 32'd0);

    // Pointer sits at 1 after the last lone grant went to requester 0.
    req_valid = 2'b11;
    #1;
    chk("ptr1_ready", 32'(req_ready), 32'd2);
    req_valid = 2'b00;

    // Restart beats goal in the same cycle.
    restart = 1'b1; goal_reached = 1'b1; step(); restart = 1'b0; goal_reached = 1'b0;
    chk("restart_count",  32'(count), 32'd0);
    chk("restart_trans",  32'(transition), 32'd0);
    chk("restart_estate", 32'(E_STATE), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("restart_start_count", 32'(count), 32'd1);

    // Climb to level 3, then goal -> END with a handshake on the exit cycle.
    frames(30);
    goal_reached = 1'b1; step(); goal_reached = 1'b0;
    frames(30);
    goal_reached = 1'b1; step(); goal_reached = 1'b0;
    chk("lvl3_settle_count", 32'(count), 32'd3);
    frames(30);
    chk("play3_trans", 32'(transition), 32'd0);
    req_row[0] = 6'd2; req_col[0] = 6'd5; req_valid = 2'b01; goal_reached = 1'b1;
    #1;
    chk("exit_ready", 32'(req_ready), 32'd1);
    step(); goal_reached = 1'b0; req_valid = 2'b11;
    #1;
    chk("end_estate",    32'(E_STATE),   32'd1);
    chk("end_count",     32'(count),     32'd3);
    chk("end_ready",     32'(req_ready), 32'd0);
    chk("exit_rsp_valid",32'(rsp_valid), 32'd1);
    chk("exit_rsp_wall", 32'(rsp_wall),  32'd3);
    req_valid = 2'b00;
    start = 1'b1; goal_reached = 1'b1; step(); start = 1'b0; goal_reached = 1'b0;
    chk("end_hold_estate", 32'(E_STATE), 32'd1);
    chk("end_hold_count",  32'(count),   32'd3);
    restart = 1'b1; step(); restart = 1'b0;
    chk("end_restart_count",  32'(count),   32'd0);
    chk("end_restart_estate", 32'(E_STATE), 32'd0);

    // Reset mid-settle, then a fresh start needs all 30 ticks.
    start = 1'b1; step(); start = 1'b0;
    frames(12);
    chk("mid_settle_trans", 32'(transition), 32'd1);
    Reset = 1'b1; step(); Reset = 1'b0;
    chk("midrst_count",     32'(count),      32'd0);
    chk("midrst_trans",     32'(transition), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid),  32'd0);
    chk("midrst_rsp_wall",  32'(rsp_wall),   32'd0);
    start = 1'b1; step(); start = 1'b0;
    th_cnt = 0;
    frames(29);
    chk("fresh_29_trans", 32'(transition), 32'd1);
    frames(1);
    chk("fresh_30_trans", 32'(transition), 32'd0);
    chk("fresh_th_cnt",   th_cnt, 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/maze_level_ctrl.md
MAZE_LEVEL_CTRL -- requirements
Module: maze_level_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEVELS, default 3: number of playable maze levels, count values 1..NUM_LEVELS, range 1..6.
REQ-002 SHALL have parameter SETTLE_FRAMES, default 30: frame ticks held between levels, range 1..255.
REQ-003 SHALL have one clock and a synchronous, active-high reset: Clk in 1, rising-edge clock; Reset in 1, synchronous active-high reset.
REQ-004 SHALL have frame_tick in 1: one-cycle pulse per video frame.
REQ-005 SHALL have start in 1 (leave title screen), goal_reached in 1 (player on goal tile), restart in 1 (return to title).
REQ-006 SHALL have count out 3 and E_STATE out 1: select inputs driving the map ROM.
REQ-007 SHALL have C_map in 3072: map currently selected by the ROM; bit (row*64 + col) = 1 means wall.
REQ-008 SHALL have req_valid in 2, req_row in 2x6, req_col in 2x6: tile queries; requester 0 is player, requester 1 is enemy.
REQ-009 SHALL have req_ready out 2, rsp_valid out 2, rsp_wall out 2: per-requester handshake and result.
REQ-010 SHALL have transition out 1: high while in SETTLE.

Function
REQ-011 SHALL implement FSM states TITLE, SETTLE, PLAY, END.
- TITLE: count=0, E_STATE=0.
- SETTLE/PLAY: count=level, E_STATE=0.
- END: count=NUM_LEVELS, E_STATE=1. Count is never 0 in END because the ROM gives count==0 priority over E_STATE.
REQ-012 SHALL move TITLE -> SETTLE on start, with level=1.
REQ-013 SHALL, in SETTLE, count frame_tick pulses and move to PLAY on the cycle the SETTLE_FRAMES-th tick is sampled; the tick counter clears on SETTLE entry.
REQ-014 SHALL, in PLAY, act on goal_reached: if level<NUM_LEVELS, level+1 and go to SETTLE; if level==NUM_LEVELS, go to END.
REQ-015 SHALL move to TITLE on restart from any state, with level=0 and tick counter cleared; restart beats start and goal_reached in the same cycle.
REQ-016 SHALL ignore goal_reached outside PLAY and start outside TITLE.
REQ-017 SHALL drive req_ready only in PLAY; req_ready is 0 in every other state.
REQ-018 SHALL grant at most one request per cycle, round-robin: the priority pointer moves to the other requester after each grant and stays put when nothing is granted.
REQ-019 SHALL grant a lone valid requester regardless of the pointer.
REQ-020 SHALL drive req_ready[i]=1 only for the requester granted this cycle, computed combinationally from req_valid and state; a handshake is req_valid[i]&req_ready[i].
REQ-021 SHALL register the result on the cycle after a handshake:
- rsp_valid[i]=1 for exactly one cycle;
- rsp_wall[i]=C_map[row*64+col], sampled on the handshake cycle;
- row>=48 returns rsp_wall=1 (out of bounds).
REQ-022 SHALL deliver a response for a handshake on the cycle the FSM leaves PLAY, using the map value sampled at the handshake.
REQ-023 SHALL hold rsp_wall at its last value when rsp_valid=0.
REQ-024 SHALL use an 8-bit saturating-free tick counter, compared against SETTLE_FRAMES-1 before increment.

Reset
REQ-025 SHALL, on Reset, set state=TITLE, level=0, tick counter=0, rr pointer=0, rsp_valid=00, rsp_wall=00.
REQ-026 SHALL give outputs after reset of count=0, E_STATE=0, transition=0, req_ready=00.
REQ-027 SHALL let Reset override every other input, including mid-SETTLE and mid-handshake; a pending response is dropped.

Structure
REQ-028 SHALL place the state enum (TITLE, SETTLE, PLAY, END) and constants MAP_ROWS=48, MAP_COLS=64, MAP_BITS=3072 in shared package maze_pkg.
REQ-029 SHALL put the 2-way round-robin grant plus the response register in sub-module collision_rr_arbiter; the FSM and level/tick counters stay in the top level.

Verification
REQ-030 SHALL cover: Reset, then start, then 30 frame_ticks -> count=1, transition high for exactly 30 ticks, then PLAY; req_ready becomes usable.
REQ-031 SHALL cover: in PLAY level 3 with NUM_LEVELS=3, goal_reached -> next cycle E_STATE=1, count=3, req_ready=00.
REQ-032 SHALL cover: both req_valid held high for 4 cycles, pointer=0 -> grants 0,1,0,1; each rsp_valid follows one cycle later.
REQ-033 SHALL cover: query row=2, col=5 with C_map bit 133=1 -> rsp_wall=1; row=50 -> rsp_wall=1; row=0, col=0 with bit 0=0 -> rsp_wall=0.
REQ-034 SHALL cover: restart and goal_reached in the same cycle in PLAY level 2 -> TITLE, count=0, next count after start is 1.
REQ-035 SHALL cover: Reset asserted mid-SETTLE with tick count 12 -> next cycle TITLE, count=0, rsp_valid=00; a fresh start needs the full 30 ticks.
